// File: rtl/alu_md_control_pkg.sv
// alu_md_control_pkg: shared ALU control codes, ALUOp encodings, funct7 constants and mul/div FSM states.
package alu_md_control_pkg;
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_RI   = 2'b00,
        ALUOP_BR   = 2'b01,
        ALUOP_ADDR = 2'b10,
        ALUOP_LUI  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;
endpackage

// File: rtl/alu_md_control_if.sv
// alu_md_control_if: decode inputs and ALU/mul-div control outputs between pipeline and control block.
interface alu_md_control_if;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       op5;
    logic       valid_i;
    logic       flush_i;
    logic [3:0] ALUCtrl;
    logic [2:0] md_op;
    logic       md_start;
    logic       md_valid;
    logic       stall_o;
    logic       illegal_o;

    modport master (
        output ALUOp, funct3, funct7, op5, valid_i, flush_i,
        input  ALUCtrl, md_op, md_start, md_valid, stall_o, illegal_o
    );
    modport slave (
        input  ALUOp, funct3, funct7, op5, valid_i, flush_i,
        output ALUCtrl, md_op, md_start, md_valid, stall_o, illegal_o
    );
endinterface

// File: rtl/alu_md_control_decode.sv
// alu_decode: stateless ALUOp/funct decode into ALU control code, illegal flag and M-instruction detect.
module alu_decode
    import alu_md_control_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       op5_i,
    output logic [3:0] alu_ctrl_o,
    output logic       illegal_o,
    output logic       is_m_o
);
    logic       m_enc, shift, alt, f7_ok, ri, bad;
    logic [3:0] base;

    always_comb begin
        ri    = alu_op_i == ALUOP_RI;
        m_enc = op5_i && funct7_i == F7_MEXT;
        shift = funct3_i[1:0] == 2'b01;
        alt   = funct7_i == F7_ALT;
        f7_ok = funct7_i == F7_ZERO || alt;
        // immediates reuse funct7 bits as data, so only R-type and shifts constrain them
        bad   = ((op5_i || shift) && !f7_ok) ||
                (op5_i && alt && funct3_i != 3'b000 && funct3_i != 3'b101);
        case (funct3_i)
            3'b000:  base = (op5_i && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  base = ALU_SLL;
            3'b010:  base = ALU_SLT;
            3'b011:  base = ALU_SLTU;
            3'b100:  base = ALU_XOR;
            3'b101:  base = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base = ALU_OR;
            default: base = ALU_AND;
        endcase
        is_m_o     = ri && m_enc && M_EXT != 0;
        illegal_o  = ri && (m_enc ? M_EXT == 0 : bad);
        alu_ctrl_o = alu_op_i == ALUOP_BR   ? ALU_SUB :
                     alu_op_i == ALUOP_ADDR ? ALU_ADD :
                     alu_op_i == ALUOP_LUI  ? ALU_PASSB :
                     (illegal_o || m_enc)   ? ALU_ADD : base;
    end
endmodule

// File: rtl/alu_md_control.sv
// alu_md_control: ALU decode plus the mul/div start, busy-count and result-valid sequencer.
module alu_md_control
    import alu_md_control_pkg::*;
#(
    parameter int M_EXT      = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input logic             clk,
    input logic             reset,
    alu_md_control_if.slave bus
);
    localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES - 1);

    md_state_e  state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [2:0] md_op_q, md_op_d;
    logic       is_m, start;

    alu_decode #(.M_EXT(M_EXT)) u_dec (
        .alu_op_i  (bus.ALUOp),
        .funct3_i  (bus.funct3),
        .funct7_i  (bus.funct7),
        .op5_i     (bus.op5),
        .alu_ctrl_o(bus.ALUCtrl),
        .illegal_o (bus.illegal_o),
        .is_m_o    (is_m)
    );

    assign start = !reset && state_q == S_IDLE && bus.valid_i && is_m && !bus.flush_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_op_d = md_op_q;
        if (bus.flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (start) begin
            state_d = S_BUSY;
            cnt_d   = bus.funct3[2] ? DIV_LD : MUL_LD;
            md_op_d = bus.funct3;
        end else if (state_q == S_BUSY) begin
            state_d = cnt_q == '0 ? S_DONE : S_BUSY;
            cnt_d   = cnt_q == '0 ? '0 : cnt_q - 6'd1;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            md_op_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_op_q <= md_op_d;
        end
    end

    // md_op is forwarded combinationally so the unit sees it alongside md_start
    assign bus.md_op    = start ? bus.funct3 : md_op_q;
    assign bus.md_start = start;
    assign bus.md_valid = state_q == S_DONE && !bus.flush_i && !reset;
    assign bus.stall_o  = start || state_q == S_BUSY;
endmodule

// File: tb/tb_alu_md_control.sv
// tb_alu_md_control: random and directed checks of decode and mul/div sequencing against a cycle-count model.
module tb_alu_md_control;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] aluop = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       op5 = 1'b0, valid = 1'b0, flush = 1'b0;

    int pass = 0, total = 0;
    int cyc = 0, t_done = 0;
    bit act = 1'b0;
    logic [2:0] mop = '0;
    logic [4:0] d1, d0;
    logic es;

    alu_md_control_if bus1 ();
    alu_md_control_if bus0 ();

    assign bus1.ALUOp = aluop;  assign bus0.ALUOp = aluop;
    assign bus1.funct3 = funct3; assign bus0.funct3 = funct3;
    assign bus1.funct7 = funct7; assign bus0.funct7 = funct7;
    assign bus1.op5 = op5;      assign bus0.op5 = op5;
    assign bus1.valid_i = valid; assign bus0.valid_i = valid;
    assign bus1.flush_i = flush; assign bus0.flush_i = flush;

    alu_md_control #(.M_EXT(1), .MUL_CYCLES(2), .DIV_CYCLES(33)) dut (.clk(clk), .reset(reset), .bus(bus1));
    alu_md_control #(.M_EXT(0), .MUL_CYCLES(2), .DIV_CYCLES(33)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
        else pass++;
    endtask

    // reference decode written straight from the instruction-set rules
    function automatic logic [4:0] dec(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                       input logic o5, input bit mext);
        int map [8];
        if (op == 2'd1) return 5'd1;
        if (op == 2'd2) return 5'd0;
        if (op == 2'd3) return 5'd10;
        if (o5 && f7 == 7'h01) return {!mext, 4'd0};
        if ((o5 || f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00 && f7 != 7'h20) return 5'h10;
        if (o5 && f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) return 5'h10;
        map = '{(o5 && f7 == 7'h20) ? 1 : 0, 6, 5, 9, 4, (f7 == 7'h20) ? 8 : 7, 3, 2};
        return {1'b0, 4'(map[f3])};
    endfunction

    function automatic bit start_cond();
        return !act && valid && aluop == 2'd0 && op5 && funct7 == 7'h01 && !flush;
    endfunction

    // transaction model: an issued op completes a fixed number of cycles after issue
    always @(posedge clk) begin
        if (reset) begin
            act <= 1'b0;
            mop <= '0;
        end else if (flush) act <= 1'b0;
        else if (start_cond()) begin
            act    <= 1'b1;
            t_done <= cyc + (funct3[2] ? 33 : 2) + 1;
            mop    <= funct3;
        end else if (act && cyc == t_done) act <= 1'b0;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            d1 = dec(aluop, funct3, funct7, op5, 1'b1);
            d0 = dec(aluop, funct3, funct7, op5, 1'b0);
            es = start_cond();
            chk("ctrl", bus1.ALUCtrl, d1[3:0]);
            chk("illegal", bus1.illegal_o, d1[4]);
            chk("md_start", bus1.md_start, es);
            chk("stall", bus1.stall_o, es || (act && cyc < t_done));
            chk("md_valid", bus1.md_valid, act && cyc == t_done && !flush);
            chk("md_op", bus1.md_op, es ? funct3 : mop);
            chk("m0_ctrl", bus0.ALUCtrl, d0[3:0]);
            chk("m0_illegal", bus0.illegal_o, d0[4]);
            chk("m0_start", bus0.md_start, 0);
            chk("m0_stall", bus0.stall_o, 0);
            chk("m0_valid", bus0.md_valid, 0);
        end
    end

    task automatic run_m(input logic [2:0] f3, output int starts, output int stalls, output int valids, output int lat);
        @(posedge clk); #1;
        aluop = 2'd0; op5 = 1'b1; funct7 = 7'h01; funct3 = f3; valid = 1'b1;
        starts = 0; stalls = 0; valids = 0; lat = -1;
        for (int i = 0; i < 80 && lat < 0; i++) begin
            @(negedge clk);
            starts += int'(bus1.md_start);
            stalls += int'(bus1.stall_o);
            valids += int'(bus1.md_valid);
            if (bus1.md_valid) lat = i;
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    initial begin
        int s, st, v, l;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", bus1.stall_o, 0);
        chk("rst_start", bus1.md_start, 0);
        chk("rst_valid", bus1.md_valid, 0);
        chk("rst_op", bus1.md_op, 0);

        @(posedge clk); #1;
        op5 = 1'b1; funct7 = 7'h20; funct3 = 3'd0;
        @(negedge clk);
        chk("sub_ctrl", bus1.ALUCtrl, 1);
        @(posedge clk); #1 op5 = 1'b0;
        @(negedge clk);
        chk("addi_ctrl", bus1.ALUCtrl, 0);
        chk("addi_ill", bus1.illegal_o, 0);
        @(posedge clk); #1 op5 = 1'b1; funct7 = 7'h01;
        @(negedge clk);
        chk("m0_mul_ill", bus0.illegal_o, 1);
        chk("m0_mul_ctrl", bus0.ALUCtrl, 0);

        run_m(3'b000, s, st, v, l);
        chk("mul_starts", s, 1); chk("mul_stalls", st, 3); chk("mul_valids", v, 1); chk("mul_lat", l, 3);
        run_m(3'b101, s, st, v, l);
        chk("divu_starts", s, 1); chk("divu_stalls", st, 34); chk("divu_valids", v, 1); chk("divu_lat", l, 34);

        @(posedge clk); #1;
        funct7 = 7'h01; funct3 = 3'b100; op5 = 1'b1; valid = 1'b1;
        @(negedge clk);
        chk("div_start", bus1.md_start, 1);
        repeat (2) @(posedge clk);
        #1 flush = 1'b1; valid = 1'b0;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", bus1.stall_o, 0);
        v = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); v += int'(bus1.md_valid); end
        chk("flush_no_valid", v, 0);
        run_m(3'b000, s, st, v, l);
        chk("post_flush_starts", s, 1); chk("post_flush_stalls", st, 3); chk("post_flush_lat", l, 3);

        @(posedge clk); #1;
        funct3 = 3'b110; valid = 1'b1;
        @(posedge clk); #1 valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rstbusy_stall", bus1.stall_o, 0);
        chk("rstbusy_valid", bus1.md_valid, 0);
        chk("rstbusy_op", bus1.md_op, 0);
        v = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); v += int'(bus1.md_valid); end
        chk("rstbusy_no_valid", v, 0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset  = $urandom_range(0, 499) == 0;
            flush  = $urandom_range(0, 63) == 0;
            valid  = $urandom_range(0, 3) != 0;
            aluop  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            op5    = 1'($urandom_range(0, 1));
            funct3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: funct7 = 7'h00;
                1: funct7 = 7'h20;
                2: funct7 = 7'h01;
                default: funct7 = 7'($urandom_range(0, 127));
            endcase
        end
        @(posedge clk); #1 reset = 1'b0; valid = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
